// File: rtl/instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : instruction_loader
// Description : Byte-stream program loader; assembles big-endian words and
//               writes them to instruction memory at sequential addresses.
// Revision    : 1.0
// ============================================================================
module instruction_loader #(
  parameter int DEPTH   = 256,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [7:0]         byteIn,
  input  logic               byteValid,
  output logic               byteReady,
  output logic               memWriteEnable,
  output logic [31:0]        memWriteAddress,
  output logic [31:0]        memWriteData,
  output logic               busy,
  output logic               done,
  output logic               error,
  output logic [COUNT_W-1:0] wordCount
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HEADER = 3'd1,
    S_LOAD   = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4,
    S_ERROR  = 3'd5
  } state_t;

  localparam logic [COUNT_W:0] C_DEPTH = (COUNT_W+1)'(DEPTH);

  state_t             state;
  state_t             state_next;
  logic [1:0]         byte_idx;
  logic [7:0]         hdr_hi;
  logic [COUNT_W-1:0] len;
  logic [31:0]        word_sr;

  logic               xfer;
  logic [COUNT_W-1:0] hdr_len;
  logic               len_bad;
  logic [COUNT_W-1:0] wc_inc;

  assign byteReady      = (state == S_HEADER) || (state == S_LOAD);
  assign memWriteEnable = (state == S_WRITE);
  assign busy           = (state == S_HEADER) || (state == S_LOAD) || (state == S_WRITE);
  assign done           = (state == S_DONE);
  assign error          = (state == S_ERROR);

  assign xfer    = byteValid && byteReady;
  assign hdr_len = COUNT_W'({hdr_hi, byteIn});
  assign len_bad = (hdr_len == '0) || ({1'b0, hdr_len} > C_DEPTH);
  assign wc_inc  = wordCount + COUNT_W'(1);

  // Word-aligned byte address; the counter is bounded by DEPTH so it never wraps.
  assign memWriteAddress = {{(30-COUNT_W){1'b0}}, wordCount, 2'b00};
  assign memWriteData    = word_sr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) state_next = S_HEADER;
      end
      S_HEADER: begin
        if (xfer && byte_idx == 2'd1) state_next = len_bad ? S_ERROR : S_LOAD;
      end
      S_LOAD: begin
        if (xfer && byte_idx == 2'd3) state_next = S_WRITE;
      end
      S_WRITE: begin
        state_next = (wc_inc == len) ? S_DONE : S_LOAD;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byte_idx  <= 2'd0;
      hdr_hi    <= 8'd0;
      len       <= '0;
      word_sr   <= 32'd0;
      wordCount <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (start) begin
            byte_idx  <= 2'd0;
            wordCount <= '0;
          end
        end
        S_HEADER: begin
          if (xfer) begin
            if (byte_idx == 2'd0) begin
              hdr_hi   <= byteIn;
              byte_idx <= 2'd1;
            end else begin
              len      <= hdr_len;
              byte_idx <= 2'd0;
            end
          end
        end
        S_LOAD: begin
          if (xfer) begin
            word_sr  <= {word_sr[23:0], byteIn};
            byte_idx <= byte_idx + 2'd1;
          end
        end
        S_WRITE: begin
          wordCount <= wc_inc;
          byte_idx  <= 2'd0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_instruction_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_instruction_loader
// Description : Directed self-checking bench for instruction_loader.
// Revision    : 1.0
// ============================================================================
module tb_instruction_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  byteIn = 8'd0;
  logic        byteValid = 1'b0;
  logic        byteReady;
  logic        memWriteEnable;
  logic [31:0] memWriteAddress;
  logic [31:0] memWriteData;
  logic        busy;
  logic        done;
  logic        error;
  logic [15:0] wordCount;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] q_addr[$];
  logic [31:0] q_data[$];

  instruction_loader #(.DEPTH(256), .COUNT_W(16)) dut (
    .clk(clk), .reset(reset), .start(start), .byteIn(byteIn), .byteValid(byteValid),
    .byteReady(byteReady), .memWriteEnable(memWriteEnable),
    .memWriteAddress(memWriteAddress), .memWriteData(memWriteData),
    .busy(busy), .done(done), .error(error), .wordCount(wordCount)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (memWriteEnable) begin
      q_addr.push_back(memWriteAddress);
      q_data.push_back(memWriteData);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    while (!byteReady && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("ready_timeout", 32'd1, 32'd0);
    byteIn    = b;
    byteValid = 1'b1;
    @(posedge clk);
    #1;
    byteValid = 1'b0;
    byteIn    = 8'($urandom);
  endtask

  task automatic gap(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_end(input int limit);
    int t = 0;
    while (!(done || error) && t < limit) begin
      @(negedge clk);
      t++;
    end
    if (t >= limit) check("end_timeout", 32'd1, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    q_addr.delete();
    q_data.delete();
  endtask

  task automatic normal_load();
    q_addr.delete();
    q_data.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h3C); send_byte(8'h08); send_byte(8'h00); send_byte(8'h05);
    send_byte(8'h21); send_byte(8'h09); send_byte(8'h00); send_byte(8'h01);
    @(negedge clk);
    check("nl_strobe", {31'd0, memWriteEnable}, 32'd1);
    check("nl_ready_wr", {31'd0, byteReady}, 32'd0);
    @(negedge clk);
    check("nl_done", {31'd0, done}, 32'd1);
    check("nl_busy", {31'd0, busy}, 32'd0);
    check("nl_wc", {16'd0, wordCount}, 32'd2);
    check("nl_nstrobe", q_addr.size(), 32'd2);
    if (q_addr.size() == 2) begin
      check("nl_a0", q_addr[0], 32'h0);
      check("nl_d0", q_data[0], 32'h3C080005);
      check("nl_a1", q_addr[1], 32'h4);
      check("nl_d1", q_data[1], 32'h21090001);
    end
  endtask

  initial begin
    int errs;
    #12;
    check("rst_ready", {31'd0, byteReady}, 32'd0);
    check("rst_we", {31'd0, memWriteEnable}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    check("rst_addr", memWriteAddress, 32'd0);
    check("rst_data", memWriteData, 32'd0);
    check("rst_wc", {16'd0, wordCount}, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    // Normal two-word load
    normal_load();

    // Length errors
    q_addr.delete(); q_data.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    check("e0_error", {31'd0, error}, 32'd1);
    check("e0_busy", {31'd0, busy}, 32'd0);
    pulse_start();
    send_byte(8'h01); send_byte(8'h01);
    @(negedge clk);
    check("e257_error", {31'd0, error}, 32'd1);
    check("e_nstrobe", q_addr.size(), 32'd0);
    pulse_start();
    check("e_clear", {31'd0, error}, 32'd0);
    check("e_busy", {31'd0, busy}, 32'd1);
    send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
    wait_end(20);
    check("e_done", {31'd0, done}, 32'd1);
    check("e_nstrobe2", q_addr.size(), 32'd1);
    if (q_addr.size() == 1) check("e_d0", q_data[0], 32'h11223344);

    // Flow control with gaps
    q_addr.delete(); q_data.delete();
    pulse_start();
    send_byte(8'h00); gap(1); send_byte(8'h01); gap(1);
    send_byte(8'hDE); gap(1); send_byte(8'hAD); gap(1);
    send_byte(8'hBE); gap(3); send_byte(8'hEF);
    @(negedge clk);
    check("fc_wr_ready", {31'd0, byteReady}, 32'd0);
    @(negedge clk);
    check("fc_done_ready", {31'd0, byteReady}, 32'd0);
    check("fc_done", {31'd0, done}, 32'd1);
    check("fc_nstrobe", q_addr.size(), 32'd1);
    if (q_addr.size() == 1) begin
      check("fc_a0", q_addr[0], 32'h0);
      check("fc_d0", q_data[0], 32'hDEADBEEF);
    end

    // Full depth
    q_addr.delete(); q_data.delete();
    pulse_start();
    send_byte(8'h01); send_byte(8'h00);
    for (int i = 0; i < 256; i++) begin
      send_byte(8'h00); send_byte(8'h00); send_byte(8'h00); send_byte(8'(i));
    end
    wait_end(20);
    check("fd_done", {31'd0, done}, 32'd1);
    check("fd_wc", {16'd0, wordCount}, 32'd256);
    check("fd_nstrobe", q_addr.size(), 32'd256);
    if (q_addr.size() == 256) begin
      check("fd_alast", q_addr[255], 32'h3FC);
      check("fd_dlast", q_data[255], 32'h000000FF);
      errs = 0;
      for (int i = 0; i < 256; i++)
        if (q_addr[i] !== 32'(i * 4) || q_data[i] !== 32'(i)) errs++;
      check("fd_all", 32'(errs), 32'd0);
    end

    // Start while busy
    q_addr.delete(); q_data.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    pulse_start();
    send_byte(8'hA4);
    send_byte(8'hB1); send_byte(8'hB2); send_byte(8'hB3); send_byte(8'hB4);
    wait_end(20);
    check("sb_done", {31'd0, done}, 32'd1);
    check("sb_nstrobe", q_addr.size(), 32'd2);
    if (q_addr.size() == 2) begin
      check("sb_d0", q_data[0], 32'hA1A2A3A4);
      check("sb_a1", q_addr[1], 32'h4);
      check("sb_d1", q_data[1], 32'hB1B2B3B4);
    end

    // Reset mid-load
    q_addr.delete(); q_data.delete();
    pulse_start();
    send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05); send_byte(8'h06);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rm_busy", {31'd0, busy}, 32'd0);
    check("rm_ready", {31'd0, byteReady}, 32'd0);
    check("rm_wc", {16'd0, wordCount}, 32'd0);
    check("rm_data", memWriteData, 32'd0);
    check("rm_addr", memWriteAddress, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    gap(8);
    check("rm_nstrobe", q_addr.size(), 32'd1);
    check("rm_idle_done", {31'd0, done}, 32'd0);
    check("rm_idle_busy", {31'd0, busy}, 32'd0);
    normal_load();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
